pht_scheduler: RTL and testbench

//   Owns a pattern history table (PHT) of 2-bit saturating branch counters.

---
 rtl/pht_pkg.sv | 23 ++
 rtl/pht_upd_fifo.sv | 63 ++++++
 rtl/pht_scheduler.sv | 96 +++++++++
 tb/tb_pht_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pht_pkg.sv
// Shared definitions for the pattern history table scheduler: counter
// encodings, saturating counter helpers and the grant FSM state type.
package pht_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef enum logic {
      LK_PRI   = 1'b0,
      UP_FORCE = 1'b1
   } grant_e;

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == ST) ? ST : c + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == SNT) ? SNT : c - 2'd1;
   endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Small synchronous FIFO holding resolved-branch updates until the table
// port is free. Pushes when full and pops when empty are ignored.
module pht_upd_fifo #(
   parameter int W     = 5,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [W-1:0]               din_i,
   output logic [W-1:0]               dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_q <= ptr_next(wr_q);
         if (do_pop)  rd_q <= ptr_next(rd_q);
         count_q <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/pht_scheduler.sv
// Pattern history table of 2-bit counters behind a single access port shared
// by fetch lookups and buffered resolve updates, with a starvation guard.
module pht_scheduler
   import pht_pkg::*;
#(
   parameter int IDX_W      = 4,
   parameter int UQ_DEPTH   = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          lk_valid,
   input  logic [IDX_W-1:0]              lk_idx,
   output logic                          lk_ready,
   output logic                          pred_valid,
   output logic                          pred_taken,
   input  logic                          up_valid,
   input  logic [IDX_W-1:0]              up_idx,
   input  logic                          up_taken,
   output logic                          up_ready,
   output logic [$clog2(UQ_DEPTH+1)-1:0] uq_count
);

   localparam int ENTRIES = 2 ** IDX_W;
   localparam int ST_W    = $clog2(STARVE_MAX + 1);

   logic [1:0]      pht_q [ENTRIES];
   grant_e          state_q, state_d;
   logic [ST_W-1:0] starve_q, starve_d;
   logic            pred_valid_q, pred_taken_q;
   logic            lk_acc, fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [IDX_W:0]  head;

   assign lk_ready   = (state_q == LK_PRI);
   assign lk_acc     = lk_valid & lk_ready;
   assign up_ready   = ~fifo_full;
   assign fifo_push  = up_valid & up_ready;
   // The port goes to the update queue only when no lookup is taking it.
   assign fifo_pop   = ~fifo_empty & ((state_q == UP_FORCE) | ~lk_valid);
   assign pred_valid = pred_valid_q;
   assign pred_taken = pred_taken_q;

   pht_upd_fifo #(
      .W     (IDX_W + 1),
      .DEPTH (UQ_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   ({up_idx, up_taken}),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (uq_count)
   );

   always_comb begin
      starve_d = starve_q;
      state_d  = state_q;
      case (state_q)
         LK_PRI: begin
            if (fifo_pop || fifo_empty) starve_d = '0;
            else if (lk_acc)            starve_d = starve_q + 1'b1;
            if (starve_d == ST_W'(STARVE_MAX)) state_d = UP_FORCE;
         end
         UP_FORCE: begin
            starve_d = '0;
            state_d  = LK_PRI;
         end
         default: begin
            starve_d = '0;
            state_d  = LK_PRI;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= LK_PRI;
         starve_q     <= '0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         for (int i = 0; i < ENTRIES; i++) pht_q[i] <= SNT;
      end else begin
         state_q      <= state_d;
         starve_q     <= starve_d;
         pred_valid_q <= lk_acc;
         pred_taken_q <= lk_acc & pht_q[lk_idx][1];
         if (fifo_pop)
            pht_q[head[IDX_W:1]] <= head[0] ? sat_inc(pht_q[head[IDX_W:1]])
                                            : sat_dec(pht_q[head[IDX_W:1]]);
      end
   end

endmodule

// File: tb/tb_pht_scheduler.sv
// Directed bench for pht_scheduler: a per-cycle vector table followed by
// hand-written sequences for saturation, starvation, FIFO full and reset.
module tb_pht_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       lk_valid = 1'b0;
   logic [3:0] lk_idx = '0;
   logic       lk_ready, pred_valid, pred_taken;
   logic       up_valid = 1'b0;
   logic [3:0] up_idx = '0;
   logic       up_taken = 1'b0;
   logic       up_ready;
   logic [1:0] uq_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pht_scheduler #(
      .IDX_W      (4),
      .UQ_DEPTH   (2),
      .STARVE_MAX (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .lk_valid   (lk_valid),
      .lk_idx     (lk_idx),
      .lk_ready   (lk_ready),
      .pred_valid (pred_valid),
      .pred_taken (pred_taken),
      .up_valid   (up_valid),
      .up_idx     (up_idx),
      .up_taken   (up_taken),
      .up_ready   (up_ready),
      .uq_count   (uq_count)
   );

   typedef struct {
      logic       lv;
      logic [3:0] li;
      logic       uv;
      logic [3:0] ui;
      logic       ut;
      logic       e_lkr;
      logic       e_upr;
      logic       e_pv;
      logic       e_pt;
      int         e_cnt;
   } vec_t;

   vec_t vec [16];

   function automatic vec_t mk(input logic lv, input int li, input logic uv,
                               input int ui, input logic ut, input logic lkr,
                               input logic upr, input logic pv, input logic pt,
                               input int cnt);
      vec_t v;
      v.lv = lv; v.li = 4'(li); v.uv = uv; v.ui = 4'(ui); v.ut = ut;
      v.e_lkr = lkr; v.e_upr = upr; v.e_pv = pv; v.e_pt = pt; v.e_cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      lk_valid = 1'b0;
      up_valid = 1'b0;
      while (uq_count != 0 && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      chk({nm, " drain"}, int'(uq_count), 0);
   endtask

   task automatic do_lookup(input int idx, input logic exp_pt, input string nm);
      @(negedge clk);
      lk_valid = 1'b1; lk_idx = 4'(idx); up_valid = 1'b0;
      #1 chk({nm, " lk_ready"}, int'(lk_ready), 1);
      @(negedge clk);
      lk_valid = 1'b0;
      #1;
      chk({nm, " pred_valid"}, int'(pred_valid), 1);
      chk({nm, " pred_taken"}, int'(pred_taken), int'(exp_pt));
   endtask

   task automatic send_upd(input int idx, input logic t, input string nm);
      @(negedge clk);
      lk_valid = 1'b0; up_valid = 1'b1; up_idx = 4'(idx); up_taken = t;
      #1 chk({nm, " up_ready"}, int'(up_ready), 1);
      @(negedge clk);
      up_valid = 1'b0;
      #1 wait_drain(nm);
   endtask

   initial begin
      //            lv li uv ui ut  lkr upr pv pt cnt
      vec[0]  = mk(0, 0, 0, 0, 0,  1,  1,  0, 0, 0);
      vec[1]  = mk(1, 5, 0, 0, 0,  1,  1,  0, 0, 0);
      vec[2]  = mk(0, 0, 0, 0, 0,  1,  1,  1, 0, 0);
      vec[3]  = mk(0, 0, 0, 0, 0,  1,  1,  0, 0, 0);
      vec[4]  = mk(0, 0, 1, 3, 1,  1,  1,  0, 0, 0);
      vec[5]  = mk(0, 0, 1, 3, 1,  1,  1,  0, 0, 1);
      vec[6]  = mk(0, 0, 1, 3, 1,  1,  1,  0, 0, 1);
      vec[7]  = mk(0, 0, 0, 0, 0,  1,  1,  0, 0, 1);
      vec[8]  = mk(1, 3, 0, 0, 0,  1,  1,  0, 0, 0);
      vec[9]  = mk(0, 0, 1, 3, 0,  1,  1,  1, 1, 0);
      vec[10] = mk(0, 0, 0, 0, 0,  1,  1,  0, 0, 1);
      vec[11] = mk(1, 3, 0, 0, 0,  1,  1,  0, 0, 0);
      vec[12] = mk(0, 0, 1, 3, 0,  1,  1,  1, 1, 0);
      vec[13] = mk(0, 0, 0, 0, 0,  1,  1,  0, 0, 1);
      vec[14] = mk(1, 3, 0, 0, 0,  1,  1,  0, 0, 0);
      vec[15] = mk(0, 0, 0, 0, 0,  1,  1,  1, 0, 0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Per-cycle table: reset state, lookup latency, queued updates, no bypass.
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         lk_valid = vec[i].lv; lk_idx = vec[i].li;
         up_valid = vec[i].uv; up_idx = vec[i].ui; up_taken = vec[i].ut;
         #1;
         chk($sformatf("row%0d lk_ready", i),   int'(lk_ready),   int'(vec[i].e_lkr));
         chk($sformatf("row%0d up_ready", i),   int'(up_ready),   int'(vec[i].e_upr));
         chk($sformatf("row%0d pred_valid", i), int'(pred_valid), int'(vec[i].e_pv));
         chk($sformatf("row%0d pred_taken", i), int'(pred_taken), int'(vec[i].e_pt));
         chk($sformatf("row%0d uq_count", i),   int'(uq_count),   vec[i].e_cnt);
      end

      // Saturation at both ends of entry 7.
      for (int k = 0; k < 5; k++) send_upd(7, 1'b1, "sat_up");
      do_lookup(7, 1'b1, "sat 5T");
      send_upd(7, 1'b0, "sat_nt1");
      do_lookup(7, 1'b1, "sat 5T1N");
      send_upd(7, 1'b0, "sat_nt2");
      do_lookup(7, 1'b0, "sat 5T2N");
      for (int k = 0; k < 3; k++) send_upd(7, 1'b0, "sat_dn");
      send_upd(7, 1'b1, "sat_t1");
      do_lookup(7, 1'b0, "sat 5N1T");
      send_upd(7, 1'b1, "sat_t2");
      do_lookup(7, 1'b1, "sat 5N2T");

      // Starvation guard: one queued update under continuous lookups.
      @(negedge clk);
      lk_valid = 1'b1; lk_idx = 4'd0; up_valid = 1'b1; up_idx = 4'd9; up_taken = 1'b1;
      #1 chk("starve c0 uq_count", int'(uq_count), 0);
      @(negedge clk);
      up_valid = 1'b0;
      #1;
      chk("starve c1 lk_ready", int'(lk_ready), 1);
      chk("starve c1 uq_count", int'(uq_count), 1);
      chk("starve c1 pred_valid", int'(pred_valid), 1);
      @(negedge clk); #1 chk("starve c2 lk_ready", int'(lk_ready), 1);
      @(negedge clk); #1 chk("starve c3 lk_ready", int'(lk_ready), 1);
      @(negedge clk); #1;
      chk("starve c4 lk_ready", int'(lk_ready), 0);
      chk("starve c4 uq_count", int'(uq_count), 1);
      @(negedge clk); #1;
      chk("starve c5 lk_ready", int'(lk_ready), 1);
      chk("starve c5 uq_count", int'(uq_count), 0);
      chk("starve c5 pred_valid", int'(pred_valid), 0);
      lk_valid = 1'b0;

      // FIFO full: lookups held, three updates to entry 12.
      @(negedge clk);
      lk_valid = 1'b1; lk_idx = 4'd0; up_valid = 1'b1; up_idx = 4'd12; up_taken = 1'b1;
      #1 chk("full a up_ready", int'(up_ready), 1);
      @(negedge clk); #1 chk("full b uq_count", int'(uq_count), 1);
      @(negedge clk); #1;
      chk("full c uq_count", int'(uq_count), 2);
      chk("full c up_ready", int'(up_ready), 0);
      @(negedge clk); #1;
      chk("full d up_ready", int'(up_ready), 0);
      chk("full d lk_ready", int'(lk_ready), 1);
      @(negedge clk); #1;
      chk("full e lk_ready", int'(lk_ready), 0);
      chk("full e up_ready", int'(up_ready), 0);
      chk("full e uq_count", int'(uq_count), 2);
      @(negedge clk); #1;
      chk("full f uq_count", int'(uq_count), 1);
      chk("full f up_ready", int'(up_ready), 1);
      @(negedge clk);
      up_valid = 1'b0;
      #1 chk("full g uq_count", int'(uq_count), 2);
      wait_drain("full");
      do_lookup(12, 1'b1, "full 3T");
      send_upd(12, 1'b0, "full_nt");
      do_lookup(12, 1'b1, "full 3T1N");

      // Reset with a full queue and a lookup being accepted.
      @(negedge clk);
      lk_valid = 1'b1; lk_idx = 4'd12; up_valid = 1'b1; up_idx = 4'd12; up_taken = 1'b1;
      #1;
      @(negedge clk); #1 chk("rst pre uq_count1", int'(uq_count), 1);
      @(negedge clk);
      up_valid = 1'b0; rst = 1'b1;
      #1;
      chk("rst pre uq_count2", int'(uq_count), 2);
      chk("rst pre lk_ready", int'(lk_ready), 1);
      @(negedge clk);
      rst = 1'b0; lk_valid = 1'b0;
      #1;
      chk("rst post uq_count", int'(uq_count), 0);
      chk("rst post pred_valid", int'(pred_valid), 0);
      chk("rst post pred_taken", int'(pred_taken), 0);
      chk("rst post up_ready", int'(up_ready), 1);
      repeat (3) @(negedge clk);
      #1 chk("rst idle uq_count", int'(uq_count), 0);
      do_lookup(12, 1'b0, "rst idx12");
      do_lookup(3, 1'b0, "rst idx3");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
